chacha_stream_ctrl: RTL
=======================

CHACHA_STREAM_CTRL -- requirements
Module: chacha_stream_ctrl

Interface
REQ-001 SHALL provide ports (name  direction  width  meaning), clock and reset first:
 clk_i  in  1  single clock; all state on rising edge
 rst_ni  in  1  reset, asynchronous assert, active-low
 req_valid_i  in  1  multi-block keystream request valid
 req_ready_o  out  1  controller can accept a request
 req_nblocks_i  in  16  number of 64-byte blocks requested
 req_counter_i  in  32  initial block counter
 abort_i  in  1  synchronous abort of the current request
 blk_ready_i  in  1  block core idle and able to start
 blk_start_o  out  1  one-cycle start pulse to block core
 blk_counter_o  out  32  counter value presented to block core
 blk_done_i  in  1  block core finished; keystream valid this cycle
 blk_keystream_i  in  512  block core keystream; word k = bits [32k+31:32k]
 ks_valid_o  out  1  keystream word valid
 ks_ready_i  in  1  downstream accepts word
 ks_data_o  out  32  keystream word
 ks_last_o  out  1  final word of final block
 busy_o  out  1  request in progress (state != IDLE)
 done_o  out  1  one-cycle pulse, request complete
 err_o  out  1  one-cycle pulse, counter overflow abort
REQ-002 SHALL use one clock domain (clk_i) and an asynchronous, active-low reset (rst_ni); no other clocks or resets.

Function
REQ-003 SHALL implement states IDLE, START, WAIT, DRAIN, FINISH, one-hot encoded.
REQ-004 IDLE: req_ready_o=1; on req_valid_i&&req_ready_o SHALL latch req_counter_i into ctr and req_nblocks_i into remaining.
REQ-005 Accepted request with nblocks=0 SHALL go IDLE->FINISH (no blk_start_o); otherwise IDLE->START.
REQ-006 START: blk_start_o=blk_ready_i; SHALL stay in START while blk_ready_i=0; on blk_ready_i=1 SHALL pulse blk_start_o exactly one cycle and go to WAIT.
REQ-007 blk_counter_o SHALL equal ctr at all times and be stable from START through WAIT.
REQ-008 WAIT: on blk_done_i SHALL capture blk_keystream_i into a 512-bit buffer, set word index to 0, go DRAIN; blk_done_i outside WAIT SHALL be ignored.
REQ-009 DRAIN: ks_valid_o=1, ks_data_o=buffer word[index]; ks_data_o/ks_last_o SHALL hold while ks_valid_o&&!ks_ready_i.
REQ-010 Each ks_valid_o&&ks_ready_i handshake SHALL advance the index by 1; words emitted in order 0..15, at most one per cycle.
REQ-011 ks_last_o SHALL be 1 only when index=15 and remaining=1.
REQ-012 Handshake on index 15: remaining=1 -> FINISH; remaining>1 and ctr!=32'hFFFFFFFF -> ctr+1, remaining-1, START; remaining>1 and ctr=32'hFFFFFFFF -> pulse err_o, go IDLE (no wrap to 0).
REQ-013 FINISH: done_o=1 for exactly one cycle, then IDLE; done_o and err_o SHALL never assert in the same cycle.
REQ-014 ctr SHALL be 32-bit unsigned; remaining 16-bit unsigned; no other arithmetic.
REQ-015 abort_i=1 in any non-IDLE state SHALL force IDLE next cycle, ks_valid_o=0 from that cycle, no done_o/err_o; a pending blk_done_i SHALL then be ignored.
REQ-016 abort_i in IDLE SHALL have no effect; abort_i has priority over all other transitions.
REQ-017 busy_o SHALL be 1 in every state except IDLE; req_ready_o SHALL equal !busy_o.
REQ-018 Outputs blk_start_o, ks_valid_o, ks_last_o, done_o, err_o SHALL be decoded from state (plus blk_ready_i for blk_start_o, index/remaining for ks_last_o).

Reset
REQ-019 rst_ni=0 SHALL asynchronously force IDLE, ctr=0, remaining=0, index=0, buffer=0; outputs: req_ready_o=1, all other outputs 0.
REQ-020 Reset mid-request SHALL discard the request; after release the block SHALL accept a new request on the first edge.

Verification
REQ-021 nblocks=1, counter=5, core done after 20 cycles, ks_ready_i=1 -> one blk_start_o with blk_counter_o=5, 16 words in order on consecutive cycles, ks_last_o on word 15, done_o one cycle later.
REQ-022 nblocks=3, counter=0, random ks_ready_i -> three starts with blk_counter_o=0,1,2; 48 words; data stable under backpressure; single ks_last_o.
REQ-023 nblocks=0 -> no blk_start_o, no ks_valid_o, done_o pulse 1 cycle after acceptance, busy_o high 1 cycle.
REQ-024 nblocks=2, counter=32'hFFFFFFFF -> one block drained, ks_last_o never asserted, err_o pulse after word 15, no second start, back in IDLE.
REQ-025 blk_ready_i held 0 for 10 cycles in START -> no blk_start_o until blk_ready_i=1, then exactly one pulse.
REQ-026 abort_i asserted in WAIT, and separately rst_ni dropped mid-DRAIN -> IDLE, ks_valid_o=0, late blk_done_i ignored, no done_o/err_o; new request then completes normally.

Source files
------------

// File: rtl/chacha_stream_ctrl_if.sv
// Handshake bundle between the keystream controller, the ChaCha block core,
// the requester and the keystream consumer.
interface chacha_stream_ctrl_if;
    logic         req_valid_i;
    logic         req_ready_o;
    logic [15:0]  req_nblocks_i;
    logic [31:0]  req_counter_i;
    logic         abort_i;
    logic         blk_ready_i;
    logic         blk_start_o;
    logic [31:0]  blk_counter_o;
    logic         blk_done_i;
    logic [511:0] blk_keystream_i;
    logic         ks_valid_o;
    logic         ks_ready_i;
    logic [31:0]  ks_data_o;
    logic         ks_last_o;
    logic         busy_o;
    logic         done_o;
    logic         err_o;

    modport slave (
        input  req_valid_i, req_nblocks_i, req_counter_i, abort_i,
        input  blk_ready_i, blk_done_i, blk_keystream_i, ks_ready_i,
        output req_ready_o, blk_start_o, blk_counter_o,
        output ks_valid_o, ks_data_o, ks_last_o, busy_o, done_o, err_o
    );

    modport master (
        output req_valid_i, req_nblocks_i, req_counter_i, abort_i,
        output blk_ready_i, blk_done_i, blk_keystream_i, ks_ready_i,
        input  req_ready_o, blk_start_o, blk_counter_o,
        input  ks_valid_o, ks_data_o, ks_last_o, busy_o, done_o, err_o
    );
endinterface

// File: rtl/chacha_stream_ctrl.sv
// Multi-block ChaCha keystream controller: sequences the block core over
// consecutive counters and streams each 512-bit block out as 16 words.
module chacha_stream_ctrl (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    chacha_stream_ctrl_if.slave   bus
);

    typedef enum logic [4:0] {
        IDLE   = 5'b00001,
        START  = 5'b00010,
        WAIT   = 5'b00100,
        DRAIN  = 5'b01000,
        FINISH = 5'b10000
    } state_e;

    state_e             state_q, state_d;
    logic [31:0]        ctr_q, ctr_d;
    logic [15:0]        rem_q, rem_d;
    logic [3:0]         idx_q, idx_d;
    logic [15:0][31:0]  buf_q, buf_d;

    logic hs, last_word, rem_one, ctr_max, abort_act;

    assign hs        = (state_q == DRAIN) && bus.ks_ready_i;
    assign last_word = (idx_q == 4'd15);
    assign rem_one   = (rem_q == 16'd1);
    assign ctr_max   = &ctr_q;
    assign abort_act = bus.abort_i && (state_q != IDLE);

    assign bus.req_ready_o   = (state_q == IDLE);
    assign bus.busy_o        = (state_q != IDLE);
    assign bus.blk_start_o   = (state_q == START) && bus.blk_ready_i && !bus.abort_i;
    assign bus.blk_counter_o = ctr_q;
    assign bus.ks_valid_o    = (state_q == DRAIN);
    assign bus.ks_data_o     = buf_q[idx_q];
    assign bus.ks_last_o     = (state_q == DRAIN) && last_word && rem_one;
    assign bus.done_o        = (state_q == FINISH) && !bus.abort_i;
    // Overflow aborts on the last word of a block when another block is still owed.
    assign bus.err_o         = hs && last_word && !rem_one && ctr_max && !bus.abort_i;

    always_comb begin
        state_d = state_q;
        ctr_d   = ctr_q;
        rem_d   = rem_q;
        idx_d   = idx_q;
        buf_d   = buf_q;
        if (abort_act) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.req_valid_i) begin
                        ctr_d   = bus.req_counter_i;
                        rem_d   = bus.req_nblocks_i;
                        state_d = (bus.req_nblocks_i == 16'd0) ? FINISH : START;
                    end
                end
                START: begin
                    if (bus.blk_ready_i) state_d = WAIT;
                end
                WAIT: begin
                    if (bus.blk_done_i) begin
                        buf_d   = bus.blk_keystream_i;
                        idx_d   = 4'd0;
                        state_d = DRAIN;
                    end
                end
                DRAIN: begin
                    if (bus.ks_ready_i) begin
                        if (!last_word) begin
                            idx_d = idx_q + 4'd1;
                        end else if (rem_one) begin
                            state_d = FINISH;
                        end else if (!ctr_max) begin
                            ctr_d   = ctr_q + 32'd1;
                            rem_d   = rem_q - 16'd1;
                            state_d = START;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
                FINISH:  state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            ctr_q   <= '0;
            rem_q   <= '0;
            idx_q   <= '0;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            ctr_q   <= ctr_d;
            rem_q   <= rem_d;
            idx_q   <= idx_d;
            buf_q   <= buf_d;
        end
    end

endmodule
